// File: rtl/hex_entry_register_if.sv
// Bundle of switch/button inputs and register outputs for the hex entry register.
// The master side drives the raw user inputs; the slave side is the register itself.
interface hex_entry_register_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned CountWidth = $clog2(NUM_DIGITS + 1);

  logic [3:0]              din;
  logic                    load_btn;
  logic                    bksp_btn;
  logic                    clear;
  logic [4*NUM_DIGITS-1:0] value;
  logic [CountWidth-1:0]   count;
  logic                    full;
  logic                    empty;
  logic                    accept_pulse;
  logic                    reject_pulse;

  modport master (
    output din, load_btn, bksp_btn, clear,
    input  value, count, full, empty, accept_pulse, reject_pulse
  );

  modport slave (
    input  din, load_btn, bksp_btn, clear,
    output value, count, full, empty, accept_pulse, reject_pulse
  );
endinterface

// File: rtl/hex_entry_register.sv
// Hex keypad entry register: debounced load/backspace buttons shift 4-bit digits in and out.
// Digit 0 (value[3:0]) is always the most recently entered digit.
module hex_entry_register #(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned OVERWRITE       = 0
) (
  input logic                  clk,
  input logic                  reset,
  hex_entry_register_if.slave  bus
);
  localparam int unsigned ValueWidth = 4 * NUM_DIGITS;
  localparam int unsigned CountWidth = $clog2(NUM_DIGITS + 1);
  localparam int unsigned DbWidth    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CountWidth-1:0] CountFull = CountWidth'(NUM_DIGITS);
  localparam logic [DbWidth-1:0]    DbLimit   = DbWidth'(DEBOUNCE_CYCLES);

  // Button index 0 is load, index 1 is backspace.
  localparam int unsigned BtnLoad = 0;
  localparam int unsigned BtnBksp = 1;

  logic [1:0]         raw;
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         level_q, level_d;
  logic [1:0]         armed_q, armed_d;
  logic [1:0]         rise;
  logic [DbWidth-1:0] cnt_q [2];
  logic [DbWidth-1:0] cnt_d [2];
  logic [1:0]         warm_q, warm_d;
  logic               warm;

  logic [ValueWidth-1:0] value_q, value_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  accept_q, accept_d;
  logic                  reject_q, reject_d;

  assign raw = {bus.bksp_btn, bus.load_btn};

  // Synchroniser output is only meaningful two edges after reset release.
  assign warm = (warm_q == 2'd2);

  always_comb begin
    warm_d = warm ? warm_q : warm_q + 2'd1;
    for (int b = 0; b < 2; b++) begin
      level_d[b] = level_q[b];
      cnt_d[b]   = cnt_q[b];
      armed_d[b] = armed_q[b];
      rise[b]    = 1'b0;
      if (sync2_q[b] == level_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == DbLimit) begin
        level_d[b] = sync2_q[b];
        cnt_d[b]   = '0;
        rise[b]    = sync2_q[b] & armed_q[b];
      end else begin
        cnt_d[b] = cnt_q[b] + DbWidth'(1);
      end
      // A button held through reset must be seen released before it can fire.
      if (warm && !sync2_q[b] && !level_q[b]) begin
        armed_d[b] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      armed_q <= '0;
      warm_q  <= '0;
      for (int b = 0; b < 2; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      armed_q <= armed_d;
      warm_q  <= warm_d;
      for (int b = 0; b < 2; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  always_comb begin
    value_d  = value_q;
    count_d  = count_q;
    accept_d = 1'b0;
    reject_d = 1'b0;
    if (bus.clear) begin
      value_d = '0;
      count_d = '0;
    end else if (rise[BtnBksp]) begin
      if (count_q != '0) begin
        value_d  = {4'h0, value_q[ValueWidth-1:4]};
        count_d  = count_q - CountWidth'(1);
        accept_d = 1'b1;
      end else begin
        reject_d = 1'b1;
      end
    end else if (rise[BtnLoad]) begin
      if (count_q != CountFull) begin
        value_d  = {value_q[ValueWidth-5:0], bus.din};
        count_d  = count_q + CountWidth'(1);
        accept_d = 1'b1;
      end else if (OVERWRITE != 0) begin
        value_d  = {value_q[ValueWidth-5:0], bus.din};
        accept_d = 1'b1;
      end else begin
        reject_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q  <= '0;
      count_q  <= '0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      value_q  <= value_d;
      count_q  <= count_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
    end
  end

  assign bus.value        = value_q;
  assign bus.count        = count_q;
  assign bus.full         = (count_q == CountFull);
  assign bus.empty        = (count_q == '0);
  assign bus.accept_pulse = accept_q;
  assign bus.reject_pulse = reject_q;
endmodule

// File: tb/tb_hex_entry_register.sv
// Self-checking bench: two instances (OVERWRITE=0 and 1) share stimulus; a scoreboard
// queue holds the expected outcome of each button event and is popped on every pulse.
module tb_hex_entry_register;
  localparam int unsigned N = 4;
  localparam int unsigned D = 4;

  typedef struct packed {
    logic [1:0]       acc;
    logic [1:0][15:0] val;
    logic [1:0][2:0]  cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din = 4'h0;
  logic       load_btn = 1'b0;
  logic       bksp_btn = 1'b0;
  logic       clear = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  exp_t        sb[$];
  logic [15:0] mval [2];
  logic [2:0]  mcnt [2];
  logic [15:0] old_val;

  always #5 clk = ~clk;

  hex_entry_register_if #(.NUM_DIGITS(N)) bus0 ();
  hex_entry_register_if #(.NUM_DIGITS(N)) bus1 ();

  assign bus0.din = din;
  assign bus0.load_btn = load_btn;
  assign bus0.bksp_btn = bksp_btn;
  assign bus0.clear = clear;
  assign bus1.din = din;
  assign bus1.load_btn = load_btn;
  assign bus1.bksp_btn = bksp_btn;
  assign bus1.clear = clear;

  hex_entry_register #(.NUM_DIGITS(N), .DEBOUNCE_CYCLES(D), .OVERWRITE(0)) dut0 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus0)
  );

  hex_entry_register #(.NUM_DIGITS(N), .DEBOUNCE_CYCLES(D), .OVERWRITE(1)) dut1 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input logic [15:0] v, input logic [2:0] c,
                           input logic f, input logic em, input logic ap, input logic rp,
                           input logic a_exp, input logic [15:0] v_exp, input logic [2:0] c_exp);
    check({tag, "_accept"}, ap, a_exp);
    check({tag, "_reject"}, rp, !a_exp);
    check({tag, "_value"}, v, v_exp);
    check({tag, "_count"}, c, c_exp);
    check({tag, "_full"}, f, c_exp == 3'd4);
    check({tag, "_empty"}, em, c_exp == 3'd0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_value0"}, bus0.value, mval[0]);
    check({tag, "_count0"}, bus0.count, mcnt[0]);
    check({tag, "_value1"}, bus1.value, mval[1]);
    check({tag, "_count1"}, bus1.count, mcnt[1]);
  endtask

  // Reference behaviour for one applied event; instance 1 overwrites when full.
  task automatic model_event(input logic l, input logic b, input logic [3:0] d);
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.acc[k] = 1'b1;
      if (b) begin
        if (mcnt[k] == 3'd0) e.acc[k] = 1'b0;
        else begin
          mval[k] = mval[k] >> 4;
          mcnt[k] = mcnt[k] - 3'd1;
        end
      end else if (l) begin
        if (mcnt[k] < 3'(N)) begin
          mval[k] = {mval[k][11:0], d};
          mcnt[k] = mcnt[k] + 3'd1;
        end else if (k == 1) begin
          mval[k] = {mval[k][11:0], d};
        end else begin
          e.acc[k] = 1'b0;
        end
      end
      e.val[k] = mval[k];
      e.cnt[k] = mcnt[k];
    end
    sb.push_back(e);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mval[k] = 16'h0;
      mcnt[k] = 3'd0;
    end
  endtask

  task automatic press(input logic l, input logic b, input logic [3:0] d);
    model_event(l, b, d);
    @(posedge clk); #1;
    din = d;
    load_btn = l;
    bksp_btn = b;
    repeat (10) @(posedge clk);
    #1;
    load_btn = 1'b0;
    bksp_btn = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus0.accept_pulse | bus0.reject_pulse | bus1.accept_pulse | bus1.reject_pulse) begin
      check("sb_event_pending", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_dut("dut0", bus0.value, bus0.count, bus0.full, bus0.empty, bus0.accept_pulse,
                  bus0.reject_pulse, e.acc[0], e.val[0], e.cnt[0]);
        check_dut("dut1", bus1.value, bus1.count, bus1.full, bus1.empty, bus1.accept_pulse,
                  bus1.reject_pulse, e.acc[1], e.val[1], e.cnt[1]);
      end
    end
  end

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    check("reset_empty", bus0.empty, 1);
    check("reset_full", bus0.full, 0);
    check("reset_pulses", {bus0.accept_pulse, bus0.reject_pulse}, 2'b00);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Fill with four digits.
    press(1'b1, 1'b0, 4'h1);
    press(1'b1, 1'b0, 4'h2);
    press(1'b1, 1'b0, 4'h3);
    press(1'b1, 1'b0, 4'h4);
    #1;
    check("fill_value", bus0.value, 16'h1234);
    check("fill_full", bus0.full, 1);

    // Load while full: reject vs overwrite.
    press(1'b1, 1'b0, 4'h5);
    #1;
    check("ovw0_value", bus0.value, 16'h1234);
    check("ovw1_value", bus1.value, 16'h2345);

    // Backspace down to empty, with one reject at the end.
    press(1'b0, 1'b1, 4'h0);
    press(1'b0, 1'b1, 4'h0);
    #1;
    check("bksp2_value", bus0.value, 16'h0012);
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 4'h0);
    #1;
    check_state("bksp_empty");
    check("bksp_empty_flag", bus0.empty, 1);

    // Bouncy press yields one digit.
    model_event(1'b1, 1'b0, 4'h7);
    @(posedge clk); #1;
    din = 4'h7;
    for (int i = 0; i < 5; i++) begin
      load_btn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      load_btn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    load_btn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    load_btn = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("bounce_value", bus0.value, 16'h0007);

    // Short glitch is ignored.
    din = 4'hE;
    load_btn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    load_btn = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_state("glitch");

    // Latency: raised before edge E0, register changes at edge E0+6.
    model_event(1'b1, 1'b0, 4'h8);
    @(posedge clk); #1;
    old_val = bus0.value;
    din = 4'h8;
    load_btn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("lat_edge5_value", bus0.value, old_val);
    @(posedge clk); #1;
    check("lat_edge6_value", bus0.value, mval[0]);
    repeat (4) @(posedge clk);
    #1;
    load_btn = 1'b0;
    repeat (10) @(posedge clk);

    // Simultaneous load and backspace: backspace wins, load silently dropped.
    press(1'b1, 1'b1, 4'hA);
    #1;
    check("both_value", bus0.value, 16'h0007);

    // Clear during a pending press discards the event.
    @(posedge clk); #1;
    din = 4'h3;
    load_btn = 1'b1;
    clear = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    clear = 1'b0;
    model_clear();
    check_state("clear");
    load_btn = 1'b0;
    repeat (10) @(posedge clk);

    // Reset mid-debounce, button still held after release.
    press(1'b1, 1'b0, 4'h4);
    @(posedge clk); #1;
    din = 4'h5;
    load_btn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_clear();
    #2;
    check_state("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_state("held_after_reset");
    load_btn = 1'b0;
    repeat (12) @(posedge clk);
    press(1'b1, 1'b0, 4'h9);
    #1;
    check("repress_value", bus0.value, 16'h0009);

    repeat (5) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
